// File: rtl/instr_fetch_unit_if.sv
// Loader and core-fetch signal bundle for instr_fetch_unit.
// master: the loader/core side; slave: the fetch unit.
interface instr_fetch_unit_if #(
    parameter int unsigned IW = 6,
    parameter int unsigned AW = 6
);
    // Loader channel
    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          load_ready;

    // Control
    logic          reload;

    // Core fetch channel
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] IR;
    logic          ir_valid;
    logic          addr_err;

    // Status
    logic [AW:0]   prog_len;
    logic          busy;

    modport master (
        output load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
        input  load_ready, IR, ir_valid, addr_err, prog_len, busy
    );

    modport slave (
        input  load_valid, load_data, load_last, reload, fetch_req, fetch_addr,
        output load_ready, IR, ir_valid, addr_err, prog_len, busy
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction store and fetch front-end.
// LOAD streams words into program memory; RUN serves fetches with one cycle
// of latency from the request edge. Addresses at or beyond prog_len return a
// NOP with addr_err, so unreset memory contents never reach the core.
module instr_fetch_unit #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IW    = 6,
    parameter int unsigned AW    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_unit_if.slave bus
);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_next;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_next;
    logic [LW-1:0] prog_len_q;
    logic [LW-1:0] prog_len_next;
    logic          load_ready_q;

    logic          accept_c;
    logic          fetch_take_c;
    logic          fetch_oor_c;

    // Request stage: captured on the request edge
    logic          fetch_v_q;
    logic          fetch_oor_q;
    logic [IW-1:0] rd_data_q;

    // Output stage: updated on the edge after the request edge
    logic [IW-1:0] ir_q;
    logic          ir_valid_q;
    logic          addr_err_q;

    logic [IW-1:0] mem [DEPTH];

    // Next-state, pointer and length update; reload overrides everything
    always_comb begin
        state_next    = state_q;
        wr_ptr_next   = wr_ptr_q;
        prog_len_next = prog_len_q;
        accept_c      = 1'b0;
        fetch_take_c  = 1'b0;
        fetch_oor_c   = LW'(bus.fetch_addr) >= prog_len_q;

        case (state_q)
            LOAD: begin
                accept_c = bus.load_valid && load_ready_q && !bus.reload;
                if (accept_c) begin
                    wr_ptr_next   = wr_ptr_q + AW'(1);
                    prog_len_next = prog_len_q + LW'(1);
                    if (bus.load_last || (prog_len_q == LW'(DEPTH - 1))) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                fetch_take_c = bus.fetch_req && !bus.reload;
            end
            default: begin
                state_next = LOAD;
            end
        endcase

        if (bus.reload) begin
            state_next    = LOAD;
            wr_ptr_next   = '0;
            prog_len_next = '0;
        end
    end

    // Control state, pointers and request stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            load_ready_q <= 1'b1;
            fetch_v_q    <= 1'b0;
            fetch_oor_q  <= 1'b0;
        end else begin
            state_q      <= state_next;
            wr_ptr_q     <= wr_ptr_next;
            prog_len_q   <= prog_len_next;
            load_ready_q <= (state_next == LOAD);
            fetch_v_q    <= fetch_take_c;
            fetch_oor_q  <= fetch_oor_c;
        end
    end

    // Program memory write port and synchronous read port (no reset)
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_ptr_q] <= bus.load_data;
        end
        if (fetch_take_c) begin
            rd_data_q <= mem[bus.fetch_addr];
        end
    end

    // Fetch result: NOP for out-of-program addresses, IR holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ir_valid_q <= fetch_v_q;
            addr_err_q <= fetch_v_q && fetch_oor_q;
            if (fetch_v_q) begin
                ir_q <= fetch_oor_q ? '0 : rd_data_q;
            end
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.busy       = load_ready_q;
    assign bus.prog_len   = prog_len_q;
    assign bus.IR         = ir_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver applies directed and random
// stimulus and updates a program/length reference model, pushing the expected
// result of every fetch; a monitor checks status each cycle and pops results.
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned IW    = 6;
    localparam int unsigned AW    = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.IW(IW), .AW(AW)) bus ();

    instr_fetch_unit #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [IW-1:0] ir;
        bit            err;
    } exp_t;

    logic [IW-1:0] m_mem [DEPTH];
    int            m_len  = 0;
    bit            m_load = 1'b1;
    exp_t          exp_q[$];
    logic [IW-1:0] last_ir = '0;
    bit            mon_on  = 1'b0;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    logic [IW-1:0] w4 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_len   = 0;
        m_load  = 1'b1;
        last_ir = '0;
        exp_q.delete();
    endtask

    // One cycle of stimulus; the model reflects the state after the next rising edge
    task automatic drive(input bit lv, input logic [IW-1:0] ld, input bit ll,
                         input bit rl, input bit fr, input logic [AW-1:0] fa);
        exp_t e;
        @(negedge clk);
        bus.load_valid = lv;
        bus.load_data  = ld;
        bus.load_last  = ll;
        bus.reload     = rl;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        if (rl) begin
            m_len  = 0;
            m_load = 1'b1;
        end else if (m_load) begin
            if (lv) begin
                m_mem[m_len] = ld;
                m_len++;
                if (ll || m_len == DEPTH) m_load = 1'b0;
            end
        end else if (fr) begin
            e.err = (int'(fa) >= m_len);
            e.ir  = e.err ? '0 : m_mem[fa];
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        drive(1'($urandom), IW'($urandom), 1'($urandom), 1'b0, 1'b1, a);
    endtask

    // Load n words with random gaps; stray fetches and load_last on idle cycles
    task automatic load_program(input int n, input bit use_last);
        int got   = 0;
        int guard = 0;
        while (got < n && m_load && guard < 1000) begin
            if ($urandom_range(0, 99) < 60) begin
                drive(1'b1, IW'($urandom), use_last && (got == n - 1), 1'b0,
                      1'($urandom), AW'($urandom));
                got++;
            end else begin
                drive(1'b0, IW'($urandom), 1'($urandom), 1'b0, 1'($urandom), AW'($urandom));
            end
            guard++;
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy",       bus.busy,       1);
        check("rst_load_ready", bus.load_ready, 1);
        check("rst_prog_len",   bus.prog_len,   0);
        check("rst_IR",         bus.IR,         0);
        check("rst_ir_valid",   bus.ir_valid,   0);
        check("rst_addr_err",   bus.addr_err,   0);
    endtask

    // Monitor: status every cycle, fetch results against the scoreboard queue
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && rst_n) begin
                check("busy",       bus.busy,       32'(m_load));
                check("load_ready", bus.load_ready, 32'(m_load));
                check("prog_len",   bus.prog_len,   32'(m_len));
                if (bus.ir_valid) begin
                    if (exp_q.size() == 0) begin
                        check("ir_valid_spurious", bus.ir_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("IR",       bus.IR,       32'(e.ir));
                        check("addr_err", bus.addr_err, 32'(e.err));
                        last_ir = e.ir;
                    end
                end else begin
                    check("IR_hold",       bus.IR,       32'(last_ir));
                    check("addr_err_idle", bus.addr_err, 0);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_last  = 1'b0;
        bus.reload     = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        w4[0] = 6'b101000;
        w4[1] = 6'b000110;
        w4[2] = 6'b110011;
        w4[3] = 6'b010101;
        model_reset();

        // Reset values while rst_n is low
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Load 4 words, fetch them back-to-back, then out-of-range addresses
        for (int i = 0; i < 4; i++) drive(1'b1, w4[i], i == 3, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) fetch(AW'(i));
        fetch(AW'(4));
        fetch(AW'(63));
        idle(3);

        // Reload coincident with a fetch; new 2-word program with a gap
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, AW'(0));
        drive(1'b1, 6'b111000, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 6'b010010, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 6'b000111, 1'b1, 1'b0, 1'b0, '0);
        fetch(AW'(0));
        fetch(AW'(1));
        fetch(AW'(2));
        idle(2);

        // Fill to capacity without load_last, then a 65th word is refused
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        load_program(DEPTH, 1'b0);
        drive(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b0, '0);
        fetch(AW'(63));
        fetch(AW'(0));
        for (int i = 0; i < 8; i++) fetch(AW'($urandom));
        idle(2);

        // Random programs, fetches, stray loads and reloads anywhere
        for (int r = 0; r < 25; r++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'($urandom), AW'($urandom));
            load_program($urandom_range(1, DEPTH), 1'($urandom));
            for (int k = 0; k < 40; k++) begin
                drive(1'($urandom), IW'($urandom), 1'($urandom),
                      $urandom_range(0, 99) < 3,
                      $urandom_range(0, 99) < 75,
                      ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                                  : AW'($urandom_range(0, m_len)));
            end
        end
        idle(3);

        // Asynchronous reset between edges after 3 accepted words
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, IW'($urandom), 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        bus.load_valid = 1'b0;
        rst_n = 1'b1;
        drive(1'b1, 6'b100001, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 6'b011110, 1'b1, 1'b0, 1'b0, '0);
        fetch(AW'(0));
        fetch(AW'(1));
        fetch(AW'(2));
        idle(4);

        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction store and fetch front-end for the processor core. A loader streams 6-bit instruction words into an internal program memory over a valid/ready port. The core then fetches words by PC address and receives them on `IR` with one-cycle registered latency. This replaces test-bench-driven `IR` stimulus with a synthesizable, self-contained instruction source.

## Interface
- `DEPTH`, 64, program memory depth in words
- `IW`, 6, instruction word width
- `AW`, 6, address width; equals log2(DEPTH)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `load_valid`  in  1  loader presents a word
- `load_data`  in  IW  instruction word to store
- `load_last`  in  1  qualifies the final word of the program
- `load_ready`  out  1  block accepts a word this cycle
- `reload`  in  1  single-cycle pulse; discard the program and return to loading
- `fetch_req`  in  1  core requests the word at `fetch_addr`
- `fetch_addr`  in  AW  fetch address, driven from PC low bits
- `IR`  out  IW  fetched instruction, registered
- `ir_valid`  out  1  one-cycle pulse when `IR` is updated by a fetch
- `addr_err`  out  1  one-cycle pulse alongside `ir_valid` for an out-of-program fetch
- `prog_len`  out  AW+1  number of words loaded (0..DEPTH)
- `busy`  out  1  high while in LOAD

## Operation
- States: LOAD and RUN. Reset enters LOAD.
- **LOAD**
  - `load_ready`=1.
  - A word is accepted when `load_valid`&&`load_ready` is high at a rising edge.
  - On acceptance: `mem[wr_ptr]`<=`load_data`, `wr_ptr`++, `prog_len`++.
  - Transition to RUN after accepting a word with `load_last`=1, or after accepting the DEPTH-th word (`prog_len`==DEPTH), whichever comes first.
  - `fetch_req` is ignored: `IR` holds its value, and `ir_valid`=0 and `addr_err`=0.
- **RUN**
  - `load_ready`=0 and `load_valid` is ignored.
  - `fetch_req`=1 at edge N updates `IR` at edge N+1 as follows:
    - If `fetch_addr` < `prog_len`, then `IR`<=`mem[fetch_addr]` and `ir_valid`=1 for one cycle.
    - Otherwise `IR`<=0 (NOP) and `ir_valid`=1, `addr_err`=1 for one cycle.
  - Back-to-back requests are allowed, one word per cycle, fully pipelined.
  - With no request, `IR` holds and `ir_valid`=0.
- **reload** (either state)
  - Next state is LOAD; `wr_ptr`<=0 and `prog_len`<=0.
  - Memory contents are not cleared.
  - An in-flight fetch still completes on the following edge; a fetch requested in the same cycle as `reload` is dropped.
- Simultaneous `reload` and an accepted load word: `reload` wins and the word is discarded.
- `load_last` on a cycle without acceptance has no effect.
- Memory has no reset. Stale contents are never returned, because every address ≥ `prog_len` returns NOP with `addr_err`.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state=LOAD, `load_ready`=1, `busy`=1, `IR`=0, `ir_valid`=0, `addr_err`=0, `prog_len`=0, `wr_ptr`=0.
- Reset asserted mid-load or mid-fetch aborts the operation immediately; outputs take reset values asynchronously.
- Load throughput: 1 word per cycle.
- LOAD→RUN occurs on the edge that accepts the final word. `load_ready`, `busy`=0 and fetch are available from the next cycle.
- Fetch latency: exactly 1 cycle, request edge to `IR`/`ir_valid`.
- `load_ready` and `busy` are registered (decoded from state); there is no combinational path from `load_valid`.
- `prog_len` width AW+1 holds DEPTH without wrap. `wr_ptr` never wraps because the transition to RUN occurs at DEPTH.

## Test plan
- **Load 4, then fetch:** load `101000`,`000110`,`110011`,`010101` with `load_last` on the 4th word.
  - Required: `prog_len`=4; `busy` falls the cycle after; fetches at addresses 0..3 on consecutive cycles return those words with 1-cycle latency and `ir_valid` high for 4 cycles.
- **Out-of-range fetch:** with `prog_len`=4, fetch address 4 and address 63.
  - Required: `IR`=`000000` and `ir_valid`=`addr_err`=1 for 1 cycle each.
- **Fill to capacity:** 64 words without `load_last`.
  - Required: RUN entered after word 64; `prog_len`=64; a 65th `load_valid` is not accepted (`load_ready`=0); address 63 returns the 64th word.
- **Backpressure/gaps:** toggle `load_valid` every other cycle during load.
  - Required: only accepted words are stored; addresses stay contiguous.
- **Reload in RUN:** pulse `reload` coincident with `fetch_req`.
  - Required: no `ir_valid`; `busy`=1 and `prog_len`=0 next cycle; a new 2-word program loads and fetches correctly; address 2 returns NOP with `addr_err`.
- **Async reset mid-load:** assert `rst_n`=0 after 3 accepted words, between clock edges.
  - Required: outputs reach reset values immediately; after release, a fresh load starts at address 0.
